regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug read-out engine for the register file. On a start pulse it walks an index range through one asynchronous register-file read port, capturing each word and streaming it out over a valid/ready interface tagged with its register index. It sits beside the core's register file, sharing a spare read port, and feeds a debug/trace sink such as a UART bridge or testbench monitor.

## Interface
- INCLUDE_ZERO, 1: 1 = x0 is dumped; 0 = index 0 is skipped.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- FirstDir  in  5  first index, sampled with Start.
- LastDir  in  5  last index (inclusive), sampled with Start.
- Abort  in  1  cancels an in-progress dump.
- ReadDir  out  5  register-file read address.
- ReadData  in  32  register-file read data, combinational from ReadDir.
- OutData  out  32  captured register value.
- OutDir  out  5  index of OutData.
- OutValid  out  1  OutData/OutDir valid.
- OutReady  in  1  sink accepts the word.
- OutLast  out  1  high with the final word of the range.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse after the last word is accepted.
- Error  out  1  one-cycle pulse on a rejected Start.

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE, Start=1:
  - Effective first = FirstDir, or 1 when INCLUDE_ZERO=0 and FirstDir=0.
  - Effective first > LastDir: pulse Error next cycle and stay IDLE.
  - Otherwise latch cur = effective first and end = LastDir; go to READ.
- READ: ReadDir = cur. Register ReadData into OutData, cur into OutDir, and (cur==end) into OutLast. Go to SEND.
- SEND: OutValid=1. On OutValid&&OutReady:
  - If cur==end, go to DONE.
  - Otherwise cur = cur+1 and go to READ.
  - cur never wraps; end ≤ 31 bounds it.
- DONE: Done=1 for one cycle, then IDLE.
- Abort=1 in READ, SEND or DONE:
  - Go to IDLE next cycle. OutValid drops, and Done is not pulsed.
  - Abort takes priority over a same-cycle handshake. That word counts as not delivered.
- Start while Busy is ignored. Abort in IDLE is ignored.
- Words are not a coherent snapshot: each word reflects register contents in its own READ cycle. A same-cycle write is not visible, because the write is synchronous.
- In IDLE, ReadDir = 0.

## Timing
- Reset (rst=0): state IDLE, cur/end/ReadDir/OutData/OutDir = 0, OutValid/OutLast/Busy/Done/Error = 0.
- Start edge to first OutValid: 2 cycles (IDLE→READ→SEND).
- Throughput: one word per 2 cycles with OutReady held high. An N-word dump with no backpressure takes 2N+1 cycles from Start to Done.
- While OutValid && !OutReady, OutData, OutDir and OutLast stay stable, and OutValid does not drop except on Abort or reset.
- Busy rises the cycle after an accepted Start and falls the cycle after DONE.
- Error and Done never assert in the same cycle.
- Reset assertion mid-dump clears everything immediately; no partial Done.

## Structure
- Shared package holds:
  - REG_COUNT = 32, DIR_W = 5, DATA_W = 32.
  - FSM state encoding constants (IDLE, READ, SEND, DONE).
- Single module, no sub-module. The output stage is three registers, not worth splitting.

## Test plan
- Full dump: preload reg i = 0x1000_0000+i, Start with 0..31, OutReady=1 → 32 words in order, OutDir=i, OutLast only on 31, Done 65 cycles after Start.
- Backpressure: range 5..7, OutReady low 3 cycles per word → each word held stable until accepted; 3 words total; Done once.
- Error: Start with FirstDir=9, LastDir=4 → Error pulse next cycle; OutValid and Busy stay 0.
- INCLUDE_ZERO=0: range 0..2 → words for indices 1, 2 only. Range 0..0 → Error.
- Abort: range 0..31, assert Abort during SEND of index 3 with OutReady=1 → index 3 not counted; IDLE next cycle; no Done. A subsequent Start 3..3 works normally.
- Reset mid-dump: rst=0 during READ of index 10 → all outputs 0 asynchronously; after release, Busy=0 until a new Start.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared widths, FSM encoding and first-index helper for regfile_dump
package regfile_dump_pkg;

    localparam int REG_COUNT = 32;
    localparam int DIR_W     = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    // With x0 excluded, a range starting at 0 begins at 1 instead.
    function automatic logic [DIR_W-1:0] eff_first(input logic [DIR_W-1:0] first,
                                                   input logic              include_zero);
        if (!include_zero && first == '0)
            return DIR_W'(1);
        return first;
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks a register index range through a read port and streams tagged words out
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter bit INCLUDE_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic [DIR_W-1:0]  FirstDir,
    input  logic [DIR_W-1:0]  LastDir,
    input  logic              Abort,
    output logic [DIR_W-1:0]  ReadDir,
    input  logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] OutData,
    output logic [DIR_W-1:0]  OutDir,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    state_e              state_q, state_d;
    logic [DIR_W-1:0]    cur_q, cur_d;
    logic [DIR_W-1:0]    end_q, end_d;
    logic [DIR_W-1:0]    read_dir_q, read_dir_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DIR_W-1:0]    out_dir_q, out_dir_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [DIR_W-1:0]    first_eff;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        end_d       = end_q;
        read_dir_d  = '0;
        out_data_d  = out_data_q;
        out_dir_d   = out_dir_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        first_eff   = eff_first(FirstDir, INCLUDE_ZERO);

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (first_eff > LastDir) begin
                        error_d = 1'b1;
                    end else begin
                        cur_d      = first_eff;
                        end_d      = LastDir;
                        read_dir_d = first_eff;
                        busy_d     = 1'b1;
                        state_d    = READ;
                    end
                end
            end
            READ: begin
                out_data_d  = ReadData;
                out_dir_d   = cur_q;
                out_last_d  = (cur_q == end_q);
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (OutReady) begin
                    out_valid_d = 1'b0;
                    if (cur_q == end_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cur_d      = cur_q + DIR_W'(1);
                        read_dir_d = cur_q + DIR_W'(1);
                        state_d    = READ;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over a same-cycle handshake: the word in flight is dropped.
        if (Abort && state_q != IDLE) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            busy_d      = 1'b0;
            read_dir_d  = '0;
            cur_d       = cur_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            end_q       <= '0;
            read_dir_q  <= '0;
            out_data_q  <= '0;
            out_dir_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            read_dir_q  <= read_dir_d;
            out_data_q  <= out_data_d;
            out_dir_q   <= out_dir_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign ReadDir  = read_dir_q;
    assign OutData  = out_data_q;
    assign OutDir   = out_dir_q;
    assign OutValid = out_valid_q;
    assign OutLast  = out_last_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Error    = error_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - scoreboard bench for regfile_dump with x0 included (dut 0) and excluded (dut 1)
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dir;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start [2];
    logic        abort_r [2];
    logic        out_ready [2];
    logic [4:0]  first_dir [2];
    logic [4:0]  last_dir [2];
    logic [4:0]  read_dir [2];
    logic [4:0]  out_dir [2];
    logic [31:0] read_data [2];
    logic [31:0] out_data [2];
    logic        out_valid [2];
    logic        out_last [2];
    logic        busy [2];
    logic        done [2];
    logic        error [2];

    logic [31:0] regs [32];
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        exp_q [$];
    int          active = 0;
    int          done_cnt [2];
    int          err_cnt [2];
    int          ready_mode [2];
    int          stall_cnt [2];
    logic        hold_pend [2];
    logic [31:0] hold_data [2];
    logic [4:0]  hold_dir [2];
    logic        hold_last [2];

    assign read_data[0] = regs[read_dir[0]];
    assign read_data[1] = regs[read_dir[1]];

    regfile_dump #(.INCLUDE_ZERO(1'b1)) dut0 (
        .clk(clk), .rst(rst), .Start(start[0]), .FirstDir(first_dir[0]), .LastDir(last_dir[0]),
        .Abort(abort_r[0]), .ReadDir(read_dir[0]), .ReadData(read_data[0]), .OutData(out_data[0]),
        .OutDir(out_dir[0]), .OutValid(out_valid[0]), .OutReady(out_ready[0]), .OutLast(out_last[0]),
        .Busy(busy[0]), .Done(done[0]), .Error(error[0])
    );

    regfile_dump #(.INCLUDE_ZERO(1'b0)) dut1 (
        .clk(clk), .rst(rst), .Start(start[1]), .FirstDir(first_dir[1]), .LastDir(last_dir[1]),
        .Abort(abort_r[1]), .ReadDir(read_dir[1]), .ReadData(read_data[1]), .OutData(out_data[1]),
        .OutDir(out_dir[1]), .OutValid(out_valid[1]), .OutReady(out_ready[1]), .OutLast(out_last[1]),
        .Busy(busy[1]), .Done(done[1]), .Error(error[1])
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sink model: mode 0 always ready, mode 1 holds ready low 3 cycles per word, mode 2 random.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (ready_mode[g] == 0) begin
                out_ready[g] = 1'b1;
            end else if (ready_mode[g] == 1) begin
                if (!out_valid[g]) begin
                    stall_cnt[g] = 0;
                    out_ready[g] = 1'b0;
                end else begin
                    out_ready[g] = (stall_cnt[g] == 3);
                    stall_cnt[g] = (stall_cnt[g] == 3) ? 0 : stall_cnt[g] + 1;
                end
            end else begin
                out_ready[g] = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops the scoreboard on each accepted word and checks the hold rules.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst) begin
                hold_pend[g] = 1'b0;
            end else begin
                if (done[g] || error[g]) check($sformatf("done_error_exclusive%0d", g), {31'd0, done[g] & error[g]}, 32'd0);
                if (error[g]) err_cnt[g]++;
                if (done[g]) begin
                    done_cnt[g]++;
                    if (active == g) check($sformatf("done_with_queue_empty%0d", g), exp_q.size(), 0);
                end
                if (hold_pend[g] && !abort_r[g]) begin
                    check($sformatf("hold_valid%0d", g), {31'd0, out_valid[g]}, 32'd1);
                    check($sformatf("hold_data%0d", g), out_data[g], hold_data[g]);
                    check($sformatf("hold_dir%0d", g), {27'd0, out_dir[g]}, {27'd0, hold_dir[g]});
                    check($sformatf("hold_last%0d", g), {31'd0, out_last[g]}, {31'd0, hold_last[g]});
                end
                hold_pend[g] = out_valid[g] && !out_ready[g] && !abort_r[g];
                hold_data[g] = out_data[g];
                hold_dir[g]  = out_dir[g];
                hold_last[g] = out_last[g];
                if (out_valid[g] && out_ready[g] && !abort_r[g]) begin
                    if (active != g || exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_word dut%0d: got dir %0d, expected no word", g, out_dir[g]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("word_data%0d", g), out_data[g], e.data);
                        check($sformatf("word_dir%0d", g), {27'd0, out_dir[g]}, {27'd0, e.dir});
                        check($sformatf("word_last%0d", g), {31'd0, out_last[g]}, {31'd0, e.last});
                    end
                end
            end
        end
    end

    task automatic check_zero(int g, string tag);
        check({tag, "_readdir"}, {27'd0, read_dir[g]}, 32'd0);
        check({tag, "_outdata"}, out_data[g], 32'd0);
        check({tag, "_outdir"}, {27'd0, out_dir[g]}, 32'd0);
        check({tag, "_outvalid"}, {31'd0, out_valid[g]}, 32'd0);
        check({tag, "_outlast"}, {31'd0, out_last[g]}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy[g]}, 32'd0);
        check({tag, "_done"}, {31'd0, done[g]}, 32'd0);
        check({tag, "_error"}, {31'd0, error[g]}, 32'd0);
    endtask

    task automatic push_range(int first, int last);
        for (int i = first; i <= last; i++) begin
            exp_t e;
            e.data = regs[i];
            e.dir  = 5'(i);
            e.last = (i == last);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(int g, int first, int last);
        @(posedge clk); #1;
        first_dir[g] = 5'(first);
        last_dir[g]  = 5'(last);
        start[g]     = 1'b1;
        @(posedge clk); #1;
        start[g]     = 1'b0;
    endtask

    task automatic run_dump(int g, int first, int last, int mode, bit check_lat);
        int eff, cyc, d0, e0;
        eff = (g == 1 && first == 0) ? 1 : first;
        ready_mode[g] = mode;
        active = g;
        d0 = done_cnt[g];
        e0 = err_cnt[g];
        exp_q.delete();
        if (eff <= last) push_range(eff, last);
        pulse_start(g, first, last);
        cyc = 1;
        if (eff > last) begin
            check("error_pulse", {31'd0, error[g]}, 32'd1);
            check("error_busy", {31'd0, busy[g]}, 32'd0);
            check("error_valid", {31'd0, out_valid[g]}, 32'd0);
            @(posedge clk); #1;
            check("error_single_cycle", {31'd0, error[g]}, 32'd0);
            check("error_busy_after", {31'd0, busy[g]}, 32'd0);
            check("error_count", err_cnt[g] - e0, 1);
            check("error_no_done", done_cnt[g] - d0, 0);
        end else begin
            check("busy_after_start", {31'd0, busy[g]}, 32'd1);
            while (!done[g] && cyc < 3000) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("done_seen", {31'd0, done[g]}, 32'd1);
            if (check_lat) check("done_latency", cyc, 2 * (last - eff + 1) + 1);
            check("busy_in_done", {31'd0, busy[g]}, 32'd1);
            @(posedge clk); #1;
            check("busy_after_done", {31'd0, busy[g]}, 32'd0);
            check("done_single_cycle", {31'd0, done[g]}, 32'd0);
            check("done_count", done_cnt[g] - d0, 1);
            check("queue_drained", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int cyc, d0;
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; abort_r[g] = 1'b0; first_dir[g] = '0; last_dir[g] = '0;
            out_ready[g] = 1'b0; ready_mode[g] = 0; stall_cnt[g] = 0;
            done_cnt[g] = 0; err_cnt[g] = 0; hold_pend[g] = 1'b0;
        end
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
        #12;
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        @(negedge clk);
        rst = 1'b1;

        run_dump(0, 0, 31, 0, 1'b1);
        run_dump(0, 5, 7, 1, 1'b0);
        run_dump(0, 9, 4, 0, 1'b0);
        run_dump(1, 0, 2, 0, 1'b1);
        run_dump(1, 0, 0, 0, 1'b0);
        run_dump(0, 0, 0, 0, 1'b1);
        run_dump(0, 31, 31, 1, 1'b0);

        // Abort during SEND of index 3 with the sink ready: that word is dropped.
        ready_mode[0] = 0; active = 0; exp_q.delete(); push_range(0, 31);
        d0 = done_cnt[0];
        pulse_start(0, 0, 31);
        cyc = 0;
        while (!(out_valid[0] && out_dir[0] == 5'd3) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reached_idx3", {27'd0, out_dir[0]}, 32'd3);
        abort_r[0] = 1'b1;
        @(posedge clk); #1;
        abort_r[0] = 1'b0;
        check("abort_busy", {31'd0, busy[0]}, 32'd0);
        check("abort_valid", {31'd0, out_valid[0]}, 32'd0);
        check("abort_remaining", exp_q.size(), 29);
        if (exp_q.size() > 0) check("abort_next_dir", {27'd0, exp_q[0].dir}, 32'd3);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt[0] - d0, 0);
        run_dump(0, 3, 3, 0, 1'b1);

        // Reset asserted while index 10 is being read.
        ready_mode[0] = 0; active = 0; exp_q.delete(); push_range(0, 31);
        d0 = done_cnt[0];
        pulse_start(0, 0, 31);
        cyc = 0;
        while (read_dir[0] != 5'd10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reset_reached_idx10", {27'd0, read_dir[0]}, 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check_zero(0, "midreset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_busy", {31'd0, busy[0]}, 32'd0);
        check("post_reset_no_done", done_cnt[0] - d0, 0);

        for (int n = 0; n < 24; n++) begin
            int g, f, l, m;
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            g = $urandom_range(0, 1);
            f = $urandom_range(0, 31);
            l = $urandom_range(0, 31);
            if (n % 3 != 0 && f > l) begin
                int t;
                t = f; f = l; l = t;
            end
            m = ($urandom_range(0, 1) == 0) ? 0 : 2;
            run_dump(g, f, l, m, m == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
